// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared types and helpers for the cyclic-prefix reorder block
package ofdm_pkg;

    // Read-side FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        BODY = 2'd2
    } rd_state_t;

    // Frame length derived from log2 size
    function automatic int nfft(input int size_buffer);
        return 1 << size_buffer;
    endfunction

    // Reverse the low 'width' bits of value; upper bits of the result are zero
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] v;
        logic [31:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = {r[30:0], v[0]};
                v = {1'b0, v[31:1]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ofdm_pingpong_ram.sv
// rtl/ofdm_pingpong_ram.sv - two-bank frame store, sync write, async read
module ofdm_pingpong_ram
    import ofdm_pkg::*;
#(
    parameter int SIZE_BUFFER = 6,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic                    wr_bank,
    input  logic [SIZE_BUFFER-1:0]  wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_bank,
    input  logic [SIZE_BUFFER-1:0]  rd_addr,
    output logic [2*DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 * nfft(SIZE_BUFFER);

    logic [2*DATA_WIDTH-1:0] mem [DEPTH];

    // Bank select forms the top address bit; storage is not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/ofdm_cp_reorder.sv
// rtl/ofdm_cp_reorder.sv - ping-pong frame reorder with cyclic prefix insertion
module ofdm_cp_reorder
    import ofdm_pkg::*;
#(
    parameter int SIZE_BUFFER = 6,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [DATA_WIDTH-1:0]  data_in_i,
    input  logic [DATA_WIDTH-1:0]  data_in_q,
    output logic                   flag_wayt_data,
    input  logic                   bitrev_en,
    input  logic [SIZE_BUFFER-1:0] cp_len,
    output logic [DATA_WIDTH-1:0]  data_out_i,
    output logic [DATA_WIDTH-1:0]  data_out_q,
    output logic                   valid_out,
    input  logic                   flag_ready_recive,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   overflow
);

    localparam int NFFT = nfft(SIZE_BUFFER);
    localparam logic [SIZE_BUFFER-1:0] LAST_ADDR = {SIZE_BUFFER{1'b1}};

    // ---------------- write side ----------------
    logic                   wr_bank;
    logic [1:0]             full;
    logic [1:0]             full_n;
    logic                   wr_bank_n;
    logic [SIZE_BUFFER-1:0] wr_cnt;
    logic                   bitrev_lat;
    logic                   wr_accept;
    logic                   wr_last;
    logic                   eff_bitrev;
    logic [SIZE_BUFFER-1:0] wr_addr;

    assign wr_accept  = valid && flag_wayt_data;
    assign wr_last    = wr_accept && (wr_cnt == LAST_ADDR);
    // The first sample of a frame uses bitrev_en directly; later ones use the latched copy
    assign eff_bitrev = (wr_cnt == '0) ? bitrev_en : bitrev_lat;
    assign wr_addr    = eff_bitrev ? SIZE_BUFFER'(bitrev(32'(wr_cnt), SIZE_BUFFER)) : wr_cnt;

    // ---------------- read side ----------------
    rd_state_t              state;
    logic                   rd_bank;
    logic [SIZE_BUFFER-1:0] rd_addr;
    logic                   new_frame;
    logic [SIZE_BUFFER:0]   cp_start_w;
    logic [SIZE_BUFFER-1:0] cp_start;
    logic                   cp_nonzero;
    logic                   load_en;
    logic                   have_beat;
    logic                   issue;
    logic                   beat_in_cp;
    logic                   beat_first;
    logic                   beat_end;
    logic                   rd_release;
    logic [SIZE_BUFFER-1:0] beat_addr;
    logic [2*DATA_WIDTH-1:0] rd_data;

    // NFFT - cp_len needs one extra bit; its MSB is set only when cp_len is zero
    assign cp_start_w = (SIZE_BUFFER+1)'(NFFT) - {1'b0, cp_len};
    assign cp_start   = cp_start_w[SIZE_BUFFER-1:0];
    assign cp_nonzero = !cp_start_w[SIZE_BUFFER];

    assign load_en = !valid_out || flag_ready_recive;

    // Select the beat the output register would take this cycle
    always_comb begin
        have_beat  = 1'b0;
        beat_in_cp = 1'b0;
        beat_first = new_frame;
        beat_addr  = rd_addr;
        case (state)
            IDLE: begin
                have_beat  = full[rd_bank];
                beat_in_cp = cp_nonzero;
                beat_first = 1'b1;
                beat_addr  = cp_start;
            end
            CP: begin
                have_beat  = 1'b1;
                beat_in_cp = 1'b1;
            end
            BODY: begin
                have_beat  = 1'b1;
            end
            default: begin
                have_beat  = 1'b0;
            end
        endcase
    end

    assign issue      = have_beat && load_en;
    assign beat_end   = !beat_in_cp && (beat_addr == LAST_ADDR);
    assign rd_release = issue && beat_end;

    // Bank occupancy after this edge: a release and a fill never target the same bank
    always_comb begin
        full_n = full;
        if (rd_release) begin
            full_n[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_n[wr_bank] = 1'b1;
        end
        wr_bank_n = wr_bank ^ wr_last;
    end

    ofdm_pingpong_ram #(
        .SIZE_BUFFER (SIZE_BUFFER),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data ({data_in_i, data_in_q}),
        .rd_bank (rd_bank),
        .rd_addr (beat_addr),
        .rd_data (rd_data)
    );

    // Write counter, bank ownership, ready flag and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank        <= 1'b0;
            wr_cnt         <= '0;
            full           <= 2'b00;
            bitrev_lat     <= 1'b0;
            flag_wayt_data <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (valid && !flag_wayt_data) begin
                overflow <= 1'b1;
            end
            if (wr_accept) begin
                if (wr_cnt == '0) begin
                    bitrev_lat <= bitrev_en;
                end
                wr_cnt <= wr_cnt + 1'b1;
            end
            wr_bank        <= wr_bank_n;
            full           <= full_n;
            flag_wayt_data <= !full_n[wr_bank_n];
        end
    end

    // Read FSM with the registered output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_addr     <= '0;
            new_frame   <= 1'b0;
            valid_out   <= 1'b0;
            data_out_i  <= '0;
            data_out_q  <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            if (load_en) begin
                valid_out   <= have_beat;
                frame_start <= have_beat && beat_first;
                frame_end   <= have_beat && beat_end;
                if (have_beat) begin
                    {data_out_i, data_out_q} <= rd_data;
                end
            end
            if (issue) begin
                new_frame <= 1'b0;
                if (beat_in_cp) begin
                    if (beat_addr == LAST_ADDR) begin
                        state   <= BODY;
                        rd_addr <= '0;
                    end else begin
                        state   <= CP;
                        rd_addr <= beat_addr + 1'b1;
                    end
                end else if (beat_addr != LAST_ADDR) begin
                    state   <= BODY;
                    rd_addr <= beat_addr + 1'b1;
                end else begin
                    // Frame done: hand the bank back and chain straight into the next one if ready
                    rd_bank <= !rd_bank;
                    if (full[!rd_bank]) begin
                        new_frame <= 1'b1;
                        rd_addr   <= cp_nonzero ? cp_start : '0;
                        state     <= cp_nonzero ? CP : BODY;
                    end else begin
                        state   <= IDLE;
                        rd_addr <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ofdm_cp_reorder.sv
// tb/tb_ofdm_cp_reorder.sv - self-checking bench for ofdm_cp_reorder
module tb_ofdm_cp_reorder;

    localparam int SB = 6;
    localparam int DW = 16;
    localparam int N  = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid = 1'b0;
    logic          bitrev_en = 1'b0;
    logic          flag_ready_recive = 1'b1;
    logic [DW-1:0] data_in_i = '0;
    logic [DW-1:0] data_in_q = '0;
    logic [SB-1:0] cp_len = '0;
    logic          flag_wayt_data;
    logic          valid_out;
    logic          frame_start;
    logic          frame_end;
    logic          overflow;
    logic [DW-1:0] data_out_i;
    logic [DW-1:0] data_out_q;

    always #5 clk = ~clk;

    ofdm_cp_reorder #(.SIZE_BUFFER(SB), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .valid             (valid),
        .data_in_i         (data_in_i),
        .data_in_q         (data_in_q),
        .flag_wayt_data    (flag_wayt_data),
        .bitrev_en         (bitrev_en),
        .cp_len            (cp_len),
        .data_out_i        (data_out_i),
        .data_out_q        (data_out_q),
        .valid_out         (valid_out),
        .flag_ready_recive (flag_ready_recive),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .overflow          (overflow)
    );

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic          fs;
        logic          fe;
    } beat_t;

    typedef struct {
        logic br;
        int   cp;
        int   pattern;
        int   rmode;
        int   nframes;
        int   exp_beats;
        int   exp_stall;
    } vec_t;

    beat_t exp_q[$];
    beat_t cap_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    ready_mode = 0;
    int    cycle = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    int    stall_cycles = 0;
    beat_t held;
    logic  stalled = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: actual=timeout required=completion", name);
    endtask

    function automatic int tb_bitrev(input int n);
        int r = 0;
        for (int k = 0; k < SB; k++) r = r * 2 + ((n >> k) & 1);
        return r;
    endfunction

    // Downstream ready pattern
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       flag_ready_recive = 1'b1;
            1:       flag_ready_recive = ~flag_ready_recive;
            2:       flag_ready_recive = ($urandom_range(0, 3) != 0);
            default: flag_ready_recive = 1'b0;
        endcase
    end

    // Output capture and stall-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        cycle++;
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(valid_out), 64'd1);
                check("stall_hold", {data_out_i, data_out_q, frame_start, frame_end},
                      {held.i, held.q, held.fs, held.fe});
            end
            if (valid_out && flag_ready_recive) begin
                cap_q.push_back('{data_out_i, data_out_q, frame_start, frame_end});
                if (cap_q.size() == 1) first_cyc = cycle;
                last_cyc = cycle;
                stalled = 1'b0;
            end else if (valid_out) begin
                held = '{data_out_i, data_out_q, frame_start, frame_end};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic push_sample(input logic [DW-1:0] si, input logic [DW-1:0] sq,
                               input logic first, input logic br);
        int guard = 0;
        while (!flag_wayt_data && guard < 5000) begin
            valid = 1'b0;
            @(posedge clk); #1;
            guard++;
            stall_cycles++;
        end
        if (guard >= 5000) fail_now("wr_timeout");
        valid     = 1'b1;
        data_in_i = si;
        data_in_q = sq;
        bitrev_en = first ? br : 1'($urandom);
        @(posedge clk); #1;
    endtask

    // Model: natural-order frame, last cp samples first, then the whole frame
    task automatic send_frame(input logic br, input int pattern);
        logic [DW-1:0] nat_i [N];
        logic [DW-1:0] nat_q [N];
        int cp;
        int idx;
        cp = int'(cp_len);
        for (int k = 0; k < N; k++) begin
            if (pattern == 0) begin
                nat_i[k] = DW'(k);
                nat_q[k] = ~DW'(k);
            end else begin
                nat_i[k] = DW'($urandom);
                nat_q[k] = DW'($urandom);
            end
        end
        for (int k = N - cp; k < N; k++)
            exp_q.push_back('{nat_i[k], nat_q[k], k == N - cp, 1'b0});
        for (int k = 0; k < N; k++)
            exp_q.push_back('{nat_i[k], nat_q[k], (cp == 0) && (k == 0), k == N - 1});
        for (int n = 0; n < N; n++) begin
            idx = br ? tb_bitrev(n) : n;
            push_sample(nat_i[idx], nat_q[idx], n == 0, br);
        end
        valid = 1'b0;
    endtask

    task automatic drain(input string name, output int count);
        int guard = 0;
        while (cap_q.size() < exp_q.size() && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 5000) fail_now({name, "_drain"});
        repeat (20) @(posedge clk);
        #1;
        count = cap_q.size();
        check({name, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++)
            check($sformatf("%s_beat%0d", name, k),
                  {cap_q[k].i, cap_q[k].q, cap_q[k].fs, cap_q[k].fe},
                  {exp_q[k].i, exp_q[k].q, exp_q[k].fs, exp_q[k].fe});
        if (ready_mode == 0 && cap_q.size() > 0)
            check({name, "_contig"}, 64'(last_cyc - first_cyc + 1), 64'(cap_q.size()));
        cap_q.delete();
        exp_q.delete();
    endtask

    vec_t vecs [6];
    int   got;

    initial begin
        vecs[0] = '{1'b1, 0,  0, 0, 1, 64,  0};
        vecs[1] = '{1'b0, 16, 0, 0, 1, 80,  0};
        vecs[2] = '{1'b0, 16, 1, 1, 1, 80,  0};
        vecs[3] = '{1'b0, 8,  1, 0, 3, 216, 8};
        vecs[4] = '{1'b1, 63, 1, 2, 2, 254, -1};
        vecs[5] = '{1'b1, 1,  1, 1, 2, 130, -1};

        #2;
        check("rst_outputs", {valid_out, frame_start, frame_end, data_out_i, data_out_q, flag_wayt_data, overflow}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rel_flag_pre", 64'(flag_wayt_data), 64'd0);
        @(posedge clk); #1;
        check("rel_flag_first_edge", 64'(flag_wayt_data), 64'd1);

        for (int v = 0; v < 6; v++) begin
            cp_len       = SB'(vecs[v].cp);
            ready_mode   = vecs[v].rmode;
            stall_cycles = 0;
            for (int f = 0; f < vecs[v].nframes; f++) begin
                send_frame(vecs[v].br, vecs[v].pattern);
                if (vecs[v].nframes == 1) begin
                    check($sformatf("v%0d_lat_before", v), 64'(valid_out), 64'd0);
                    @(posedge clk); #1;
                    check($sformatf("v%0d_lat_first", v), {valid_out, frame_start}, 64'd3);
                end
            end
            if (vecs[v].exp_stall >= 0)
                check($sformatf("v%0d_stall", v), 64'(stall_cycles), 64'(vecs[v].exp_stall));
            drain($sformatf("v%0d", v), got);
            check($sformatf("v%0d_beats", v), 64'(got), 64'(vecs[v].exp_beats));
            check($sformatf("v%0d_overflow", v), 64'(overflow), 64'd0);
        end

        for (int r = 0; r < 3; r++) begin
            int cp;
            logic br;
            cp = $urandom_range(0, N - 1);
            br = 1'($urandom_range(0, 1));
            cp_len     = SB'(cp);
            ready_mode = 2;
            send_frame(br, 1);
            send_frame(~br, 1);
            drain($sformatf("rnd%0d", r), got);
            check($sformatf("rnd%0d_beats", r), 64'(got), 64'(2 * (N + cp)));
        end

        // Overflow: both banks held full by a stalled sink, then valid forced high
        ready_mode = 3;
        cp_len     = 6'd8;
        send_frame(1'b0, 1);
        send_frame(1'b1, 1);
        check("ovf_flag_low", 64'(flag_wayt_data), 64'd0);
        check("ovf_before", 64'(overflow), 64'd0);
        valid     = 1'b1;
        data_in_i = 16'hdead;
        data_in_q = 16'hbeef;
        repeat (5) @(posedge clk);
        #1;
        valid = 1'b0;
        check("ovf_set", 64'(overflow), 64'd1);
        ready_mode = 0;
        drain("ovf_held", got);
        check("ovf_sticky", 64'(overflow), 64'd1);
        send_frame(1'b0, 0);
        drain("ovf_next", got);
        check("ovf_sticky2", 64'(overflow), 64'd1);

        // Reset in the middle of the body of an output frame
        cp_len     = 6'd16;
        ready_mode = 0;
        send_frame(1'b0, 0);
        begin
            int guard = 0;
            while (cap_q.size() < 30 && guard < 2000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 2000) fail_now("rst_wait");
        end
        reset = 1'b0;
        #1;
        check("rst_mid_outputs", {valid_out, frame_start, frame_end, data_out_i, data_out_q, overflow}, 64'd0);
        cap_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_flag", 64'(flag_wayt_data), 64'd1);
        cp_len = 6'd4;
        send_frame(1'b0, 0);
        drain("rst_after", got);
        check("rst_after_beats", 64'(got), 64'd68);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ofdm_cp_reorder.md
Name: ofdm_cp_reorder

Overview:
- Streaming post-processor for the FFT/IFFT core output.
- Accepts one complex frame of NFFT samples in bit-reversed or natural order and stores it in a ping-pong buffer.
- Emits the frame in natural order with a runtime-selectable cyclic prefix prepended.
- Sits between myFFT (TYPE "invers") and the OFDM transmit path; uses the same valid / flag_wayt_data / flag_ready_recive handshake style.

Parameters:
- SIZE_BUFFER, 6, log2 of frame length; NFFT = 2**SIZE_BUFFER.
- DATA_WIDTH, 16, width of each of I and Q.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  input sample valid.
- data_in_i  in  DATA_WIDTH  input I.
- data_in_q  in  DATA_WIDTH  input Q.
- flag_wayt_data  out  1  ready to accept input; high when a write bank is free.
- bitrev_en  in  1  1 = input arrives bit-reversed; sampled on first sample of each frame.
- cp_len  in  SIZE_BUFFER  cyclic prefix length, 0..NFFT-1; sampled when a frame starts output.
- data_out_i  out  DATA_WIDTH  output I.
- data_out_q  out  DATA_WIDTH  output Q.
- valid_out  out  1  output sample valid.
- flag_ready_recive  in  1  downstream ready.
- frame_start  out  1  qualifies the first output beat of a frame (first CP sample, or sample 0 if cp_len=0).
- frame_end  out  1  qualifies the last output beat (natural sample NFFT-1).
- overflow  out  1  sticky; set when valid=1 while flag_wayt_data=0.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; both banks empty; write bank = 0; read FSM = IDLE; overflow = 0.
- Reset mid-frame: partial input and output frames are discarded. After release, flag_wayt_data = 1 on the first clk edge.

Write side:
- Accept on an edge where valid && flag_wayt_data.
- wr_cnt counts 0..NFFT-1.
- Write address = bitrev(wr_cnt) if the latched bitrev_en is 1, else wr_cnt. Samples are therefore always stored in natural order.
- On the accept with wr_cnt = NFFT-1: mark the bank full, wr_cnt wraps to 0, toggle the write bank.
- flag_wayt_data = 0 while the current write bank is full.
- A dropped input sets overflow; the sample is not written and wr_cnt does not advance.

Read FSM (states IDLE, CP, BODY):
- IDLE -> CP when the read bank is full and cp_len != 0; IDLE -> BODY when the read bank is full and cp_len = 0. cp_len is latched on this transition.
- CP: read addresses NFFT-cp_len .. NFFT-1; after the last CP beat is accepted -> BODY.
- BODY: read addresses 0..NFFT-1. On acceptance of address NFFT-1:
  - release the bank (full = 0) and toggle the read bank;
  - go to CP or BODY directly if the other bank is already full (no bubble); otherwise go to IDLE.
- Memory read is asynchronous (distributed array). The output stage is a single register that loads when !valid_out || flag_ready_recive.
- Stall: while valid_out && !flag_ready_recive, data_out, frame_start and frame_end hold stable.

Timing:
- Latency: last input accepted on edge k -> bank full after edge k -> valid_out = 1 with the first beat after edge k+1.
- Throughput: one beat per cycle on each side. Because each frame is NFFT+cp_len output beats vs NFFT input beats, the input stalls by cp_len cycles per frame in steady state.

Simultaneous events:
- Bank release and bank fill on the same edge: the release takes effect first, so flag_wayt_data stays 1 if the newly toggled write bank is the one just released.
- A frame boundary on input and output on the same edge is legal.

Arithmetic:
- Addresses are SIZE_BUFFER bits and wrap modulo NFFT.
- NFFT-cp_len is computed in SIZE_BUFFER+1 bits.
- Data passes through unmodified (no scaling).

Decomposition:
- Shared package ofdm_pkg holds:
  - FSM state localparams (IDLE=0, CP=1, BODY=2);
  - the bitrev function parametrised by SIZE_BUFFER;
  - the NFFT derivation.
- One sub-module, ofdm_pingpong_ram: two banks of NFFT x 2*DATA_WIDTH, one write port and one asynchronous read port, with bank-select inputs. The FSMs, counters and output register stay in ofdm_cp_reorder.

Test Plan:
- Bit-reversed input: SIZE_BUFFER=6, bitrev_en=1, cp_len=0, input sample n carries I=bitrev(n), Q=~bitrev(n). Required: 64 outputs with I = 0..63 ascending, frame_start on I=0, frame_end on I=63, first valid_out one cycle after the last accept.
- Natural input with prefix: bitrev_en=0, cp_len=16, input I=0..63. Required: 80 beats, I = 48..63 then 0..63, frame_start on the first 48, frame_end on the final 63.
- Output backpressure: flag_ready_recive toggled 1,0,1,0 during output. Required: data stable during stalls; full sequence delivered with no loss or duplication.
- Back-to-back frames: three frames, valid continuous, cp_len=8, ready=1. Required:
  - flag_wayt_data falls after frame 2 fills and rises when frame 1's last beat is accepted;
  - output frames contiguous (72 beats each, no gaps);
  - overflow = 0.
- Overflow: valid forced high for 5 cycles while flag_wayt_data=0. Required: overflow = 1 and stays 1; the next accepted frame is output correctly.
- Reset mid-output: reset=0 during a BODY beat. Required: valid_out, frame_start, frame_end, data_out = 0 immediately. After release, a new frame with cp_len=4 outputs I = 60..63, 0..63 correctly.
